// File: rtl/byte_mem_pkg.sv
// byte_mem_pkg: access-size encodings, FSM states and size decode shared by byte_mem_hs
package byte_mem_pkg;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction
endpackage

// File: rtl/byte_mem_lane_ext.sv
// byte_mem_lane_ext: keeps the low size bytes of a gathered word and sign/zero extends the rest
//   raw  : bytes gathered little-endian from storage
//   size : access size code, uns : 1 = zero-extend
//   data : extended load data
module byte_mem_lane_ext import byte_mem_pkg::*; #(
  parameter int DATA_BYTES = 4
) (
  input  logic [DATA_BYTES*8-1:0] raw,
  input  logic [1:0]              size,
  input  logic                    uns,
  output logic [DATA_BYTES*8-1:0] data
);
  logic [3:0] nb;
  logic       fill;
  always_comb begin
    nb = size_bytes(size);
    fill = 1'b0;
    for (int k = 0; k < DATA_BYTES; k++) if (4'(k + 1) == nb) fill = ~uns & raw[8*k+7];
    for (int k = 0; k < DATA_BYTES; k++) data[8*k +: 8] = (4'(k) < nb) ? raw[8*k +: 8] : {8{fill}};
  end
endmodule

// File: rtl/byte_mem_hs.sv
// byte_mem_hs: byte-addressed little-endian data memory with valid/ready requests and wait states
//   clk, rst (async, active-high)
//   req_valid/req_ready handshake with req_we, req_addr, req_wdata, req_size, req_unsigned
//   rsp_valid one-cycle pulse with rsp_rdata and rsp_err held until the next response
module byte_mem_hs import byte_mem_pkg::*; #(
  parameter int DATA_BYTES       = 4,
  parameter int ADDR_WIDTH       = 32,
  parameter int DEPTH            = 1024,
  parameter int WAIT_STATES      = 0,
  parameter int ALLOW_MISALIGNED = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_BYTES*8-1:0] req_wdata,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  output logic                    rsp_valid,
  output logic [DATA_BYTES*8-1:0] rsp_rdata,
  output logic                    rsp_err
);
  localparam int DW = DATA_BYTES * 8;
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] W_LAST = 4'(WAIT_STATES - 1);
  state_e                state, state_n;
  logic [3:0]            cnt, nb;
  logic                  l_we, l_uns, s_we, s_uns, err, commit;
  logic [1:0]            l_size, s_size;
  logic [ADDR_WIDTH-1:0] l_addr, s_addr;
  logic [ADDR_WIDTH:0]   a_end;
  logic [DW-1:0]         l_wdata, s_wdata, raw, ext;
  logic [IW-1:0]         base;
  logic [7:0]            mem [DEPTH];
  // With zero wait states RESP is entered on the acceptance edge itself, so the
  // access is computed from the live request in IDLE and the latched one otherwise.
  always_comb begin
    req_ready = state == IDLE && !rst;
    rsp_valid = state == RESP;
    s_we = (state == IDLE) ? req_we : l_we;
    s_uns = (state == IDLE) ? req_unsigned : l_uns;
    s_size = (state == IDLE) ? req_size : l_size;
    s_addr = (state == IDLE) ? req_addr : l_addr;
    s_wdata = (state == IDLE) ? req_wdata : l_wdata;
    nb = size_bytes(s_size);
    a_end = {1'b0, s_addr} + (ADDR_WIDTH+1)'(nb);
    err = nb > 4'(DATA_BYTES) || a_end > (ADDR_WIDTH+1)'(DEPTH) ||
          (ALLOW_MISALIGNED == 0 && (s_addr[3:0] & (nb - 4'd1)) != 4'd0);
    base = s_addr[IW-1:0];
    for (int k = 0; k < DATA_BYTES; k++) raw[8*k +: 8] = mem[base + IW'(k)];
    state_n = (state == IDLE) ? ((req_valid && req_ready) ? ((WAIT_STATES > 0) ? WAIT : RESP) : IDLE) :
              (state == WAIT) ? ((cnt == W_LAST) ? RESP : WAIT) : IDLE;
    commit = state_n == RESP;
  end
  byte_mem_lane_ext #(.DATA_BYTES(DATA_BYTES)) u_ext (
    .raw  (raw),
    .size (s_size),
    .uns  (s_uns),
    .data (ext)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      l_we <= 1'b0;
      l_uns <= 1'b0;
      l_size <= '0;
      l_addr <= '0;
      l_wdata <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == WAIT) ? cnt + 4'd1 : 4'd0;
      if (req_valid && req_ready) begin
        l_we <= req_we;
        l_uns <= req_unsigned;
        l_size <= req_size;
        l_addr <= req_addr;
        l_wdata <= req_wdata;
      end
      if (commit) begin
        rsp_err <= err;
        rsp_rdata <= (err || s_we) ? '0 : ext;
      end
    end
  always_ff @(posedge clk)
    if (commit && s_we && !err)
      for (int k = 0; k < DATA_BYTES; k++)
        if (4'(k) < nb) mem[base + IW'(k)] <= s_wdata[8*k +: 8];
endmodule

// File: tb/tb_byte_mem_hs.sv
// tb_byte_mem_hs: drives a zero-wait and a three-wait byte_mem_hs against a byte-array reference model
module tb_byte_mem_hs;
  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v3, ready0, ready3, we_i, uns_i;
  logic [31:0] addr, wdata, rd0, rd3;
  logic [1:0]  size;
  logic        rsp_v0, rsp_v3, err0, err3;
  logic [7:0]  ref_mem [1024];
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  byte_mem_hs #(.DATA_BYTES(4), .ADDR_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0), .ALLOW_MISALIGNED(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(ready0), .req_we(we_i), .req_addr(addr),
    .req_wdata(wdata), .req_size(size), .req_unsigned(uns_i), .rsp_valid(rsp_v0), .rsp_rdata(rd0), .rsp_err(err0)
  );
  byte_mem_hs #(.DATA_BYTES(4), .ADDR_WIDTH(32), .DEPTH(1024), .WAIT_STATES(3), .ALLOW_MISALIGNED(0)) u3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(ready3), .req_we(we_i), .req_addr(addr),
    .req_wdata(wdata), .req_size(size), .req_unsigned(uns_i), .rsp_valid(rsp_v3), .rsp_rdata(rd3), .rsp_err(err3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                       input bit uns, output bit e, output logic [31:0] d);
    int nb = 1 << sz;
    e = (nb > 4) || ({32'd0, a} + 64'(nb) > 64'd1024) || (a % 32'(nb) != 0);
    d = 32'd0;
    if (!e && we)
      for (int k = 0; k < nb; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
    if (!e && !we) begin
      for (int k = 0; k < nb; k++) d = d | (32'(ref_mem[a + 32'(k)]) << (8*k));
      if (!uns && nb < 4 && d[8*nb-1]) d = d | (32'hFFFF_FFFF << (8*nb));
    end
  endtask

  task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz, input bit uns);
    bit          e;
    logic [31:0] d;
    model(we, a, wd, sz, uns, e, d);
    chk("ready_before", {ready0, ready3}, 2'b11);
    we_i = we; addr = a; wdata = wd; size = sz; uns_i = uns; v0 = 1'b1; v3 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0; v3 = 1'b0;
    chk("ws0_valid", rsp_v0, 1);
    chk("ws0_err", err0, e);
    chk("ws0_rdata", rd0, d);
    chk("ws3_ready_low", ready3, 0);
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk); #1;
      chk("ws3_valid", rsp_v3, c == 4);
      if (c == 2) chk("ws0_pulse_end", rsp_v0, 0);
    end
    chk("ws3_err", err3, e);
    chk("ws3_rdata", rd3, d);
    @(posedge clk); #1;
    chk("ws3_pulse_end", rsp_v3, 0);
    chk("ws3_hold", rd3, d);
  endtask

  initial begin
    bit          e;
    logic [31:0] d;
    logic [31:0] a;
    logic [1:0]  s;
    rst = 1'b1; v0 = 1'b0; v3 = 1'b0; we_i = 1'b0; uns_i = 1'b0; addr = '0; wdata = '0; size = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {rsp_v0, rsp_v3}, 2'b00);
    chk("rst_err", {err0, err3}, 2'b00);
    chk("rst_rdata", {rd0, rd3}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {ready0, ready3}, 2'b11);
    for (int i = 0; i < 64; i++) xact(1, 32'(i * 4), $urandom, 2, 0);
    xact(1, 1016, $urandom, 2, 0);
    xact(1, 1020, $urandom, 2, 0);
    xact(1, 'h10, 'hDEAD_BEEF, 2, 0);
    xact(0, 'h10, 0, 2, 0);
    chk("t1_word", rd0, 'hDEAD_BEEF);
    xact(0, 'h13, 0, 0, 0);
    chk("t2_sbyte", rd3, 'hFFFF_FFDE);
    xact(0, 'h13, 0, 0, 1);
    chk("t2_ubyte", rd3, 'h0000_00DE);
    xact(0, 'h12, 0, 1, 0);
    chk("t2_shalf", rd3, 'hFFFF_DEAD);
    xact(1, 'h21, 'h1234, 1, 0);
    chk("t3_misalign_err", {err0, err3}, 2'b11);
    xact(0, 'h21, 0, 0, 1);
    xact(0, 'h22, 0, 0, 1);
    xact(0, 1022, 0, 2, 0);
    chk("t4_range_err", {err0, err3}, 2'b11);
    xact(0, 'hFFFF_FFFE, 0, 2, 0);
    chk("t4_wrap_err", {err0, err3, rd3}, {2'b11, 32'd0});
    for (int i = 0; i < 120; i++) begin
      s = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'(1016 + $urandom_range(0, 15));
        1: a = 32'hFFFF_F000 | $urandom;
        default: a = 32'($urandom_range(0, 255));
      endcase
      xact(1'($urandom_range(0, 1)), a, $urandom, s, 1'($urandom_range(0, 1)));
    end
    model(0, 'h10, 0, 2, 1, e, d);
    we_i = 1'b0; addr = 'h10; size = 2; uns_i = 1'b1; v3 = 1'b1;
    chk("t5_ready_start", ready3, 1);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk("t5_ready", ready3, c == 5);
      chk("t5_valid", rsp_v3, c == 4);
      if (c == 4) chk("t5_rdata", rd3, d);
    end
    v3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_second_valid", rsp_v3, 1);
    @(posedge clk); #1;
    chk("t5_idle_ready", ready3, 1);
    we_i = 1'b1; addr = 'h40; size = 0; wdata = {24'd0, ~ref_mem['h40]}; v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    chk("t6_in_wait", ready3, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_outputs", {rsp_v3, err3, rd3, rd0}, 66'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_ready", {ready0, ready3}, 2'b11);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("t6_no_rsp", rsp_v3, 0);
    end
    xact(0, 'h40, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/byte_mem_hs.md
Name: byte_mem_hs

Overview:
Parametrised successor to the team's asynchronous byte-array data memory. Adds:
- a valid/ready request channel and a one-cycle response pulse;
- a configurable number of wait states;
- sign/zero extension on loads;
- misaligned and out-of-range error detection.

It sits between the core's load/store unit and backing storage. Little-endian, byte-addressed.

Parameters:
DATA_BYTES, 4, bytes per data word (4 or 8)
ADDR_WIDTH, 32, request address width
DEPTH, 1024, total bytes of storage
WAIT_STATES, 0, extra cycles between acceptance and response (0..15)
ALLOW_MISALIGNED, 0, 1 = unaligned accesses permitted; 0 = flagged as error

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_BYTES*8  store data, LSB-aligned
req_size  in  2  00 = 1 B, 01 = 2 B, 10 = 4 B, 11 = 8 B
req_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_BYTES*8  extended load data (0 for stores and errors)
rsp_err  out  1  access rejected; valid only with rsp_valid

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; wait counter = 0.
  - req_ready = 1 once rst deasserts.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = 1 only in IDLE.
  - IDLE: on req_valid && req_ready, latch we/addr/wdata/size/unsigned. Next state is WAIT if WAIT_STATES > 0, else RESP.
  - WAIT: counter increments each cycle. After WAIT_STATES cycles, go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, then return to IDLE. No back-to-back acceptance in RESP.
- Commit point: the memory access (write, and read-data capture) happens on the edge that enters RESP. Total latency from acceptance edge to rsp_valid = WAIT_STATES + 1 cycles.
- Error conditions (checked on latched request); any one sets rsp_err = 1, suppresses the write, and forces rdata = 0:
  - size bytes (1 << size) > DATA_BYTES;
  - addr + size bytes > DEPTH, computed at ADDR_WIDTH+1 bits so wrap-around is an error, never aliasing;
  - ALLOW_MISALIGNED = 0 and addr mod size bytes != 0.
- Store: writes only bytes k < (1 << size): mem[addr+k] = wdata[8k +: 8]. rsp_rdata = 0.
- Load: gather bytes k < (1 << size) little-endian. If req_unsigned = 0, fill upper bytes with the MSB of the top loaded byte; else fill with 0. Full-width loads pass through unchanged.
- Requests arriving while req_ready = 0 are ignored. The requester must hold its signals until accepted.
- Reset mid-operation: the latched request is discarded, no write occurs, and no response is issued.
- rsp_rdata and rsp_err hold their values after the pulse until the next response, or zero after reset.

Decomposition:
- Package byte_mem_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - FSM state enum;
  - function size_bytes(size).
- Sub-module byte_mem_lane_ext: purely combinational gather plus sign/zero extension of the read bytes, given size and unsigned.
- Storage array, FSM and error checker live in the top.

Test Plan:
1. WAIT_STATES = 0, store word 0xDEADBEEF at 0x10, then load word at 0x10 → rsp_valid exactly 1 cycle after each acceptance; rdata = 0xDEADBEEF; err = 0.
2. After test 1:
   - signed byte load at 0x13 → rdata = 0xFFFFFFDE;
   - unsigned byte load at 0x13 → 0x000000DE;
   - signed half load at 0x12 → 0xFFFFDEAD.
3. Store half 0x1234 at 0x21 with ALLOW_MISALIGNED = 0 → rsp_err = 1. Subsequent byte loads at 0x21/0x22 return pre-test values.
4. Load word at DEPTH-2 (1022) → rsp_err = 1, rdata = 0. Load word at 0xFFFFFFFE → rsp_err = 1 (no wrap).
5. WAIT_STATES = 3, hold req_valid high continuously → req_ready low for 4 cycles after acceptance; rsp_valid 4 cycles after acceptance; next acceptance on the cycle after the RESP state.
6. Assert rst during WAIT of a store to 0x40 → rsp_valid never pulses, byte at 0x40 unchanged, req_ready = 1 after rst falls.
